// File: rtl/asphalt_key_ctrl.sv
// Pushbutton synchroniser, debouncer and press-event capture with an Avalon-MM slave and irq.
// Optional auto-repeat while a key is held: define KEY_AUTOREPEAT_EN.
module asphalt_key_ctrl #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [N_KEYS-1:0] in_port,
    output logic              irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;
    logic [N_KEYS-1:0] syn;
    logic [N_KEYS-1:0] state;
    logic [N_KEYS-1:0] set_evt;

    logic [N_KEYS-1:0] irqmask_reg;
    logic [N_KEYS-1:0] irqmask_next;
    logic [N_KEYS-1:0] edgecap_reg;
    logic [N_KEYS-1:0] edgecap_next;
    logic [N_KEYS-1:0] w1c;
    logic [31:0]       readdata_reg;
    logic [31:0]       rd_word;
    logic              irq_reg;

    // Synchroniser holds the raw active-low pin level, so reset to 1 means released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    assign syn = ~sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [CW-1:0] cnt_reg;
            logic          state_bit_reg;
            logic          accept_press;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg       <= '0;
                    state_bit_reg <= 1'b0;
                end else if (syn[gi] == state_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_bit_reg <= syn[gi];
                    cnt_reg       <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign state[gi]    = state_bit_reg;
            assign accept_press = syn[gi] & ~state_bit_reg & (cnt_reg == CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
            localparam int RW = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0] rpt_reg;
            logic          rpt_fire;

            // Counts only while the debounced key is down; period restarts on every fire.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rpt_reg <= '0;
                end else if (!state_bit_reg || rpt_reg == RPT_LAST) begin
                    rpt_reg <= '0;
                end else begin
                    rpt_reg <= rpt_reg + RW'(1);
                end
            end

            assign rpt_fire    = state_bit_reg & (rpt_reg == RPT_LAST);
            assign set_evt[gi] = accept_press | rpt_fire;
`else
            assign set_evt[gi] = accept_press;
`endif
        end
    endgenerate

    always_comb begin
        irqmask_next = irqmask_reg;
        w1c          = '0;
        if (write && address == 2'd2) irqmask_next = writedata[N_KEYS-1:0];
        if (write && address == 2'd3) w1c = writedata[N_KEYS-1:0];
        // Set is OR-ed in after the clear so a coincident event survives.
        edgecap_next = (edgecap_reg & ~w1c) | set_evt;
    end

    always_comb begin
        rd_word = '0;
        case (address)
            2'd0:    rd_word[N_KEYS-1:0] = state;
            2'd2:    rd_word[N_KEYS-1:0] = irqmask_reg;
            2'd3:    rd_word[N_KEYS-1:0] = edgecap_reg;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            irqmask_reg <= irqmask_next;
            edgecap_reg <= edgecap_next;
            irq_reg     <= |(edgecap_next & irqmask_next);
            if (read) readdata_reg <= rd_word;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

endmodule
